axi_pmp_err_responder: RTL and testbench
========================================

// Module: axi_pmp_err_responder
// PURPOSE
//  AXI4 terminating responder for transactions that the IO-PMP denies. The IO-PMP routes
//  a rejected AW/W or AR request to this block instead of the downstream master port.
//  The block consumes the full request, including every W beat, and returns protocol-correct
//  B and R responses. Each response carries the original ID, an error code and the exact burst length.
//  Write and read channels are independent. Each channel has at most one transaction outstanding.
// PARAMETERS
//  DATA_WIDTH   32        width of s_axi_rdata in bits
//  ID_WIDTH     8         width of all ID signals
//  ERR_RESP     2'b11     response code driven on bresp/rresp (DECERR; 2'b10 = SLVERR)
//  RDATA_FILL   32'h0     constant driven on rdata for every error beat (zero-extended/truncated to DATA_WIDTH)
// PORTS
//  clk             in   1           clock; all logic on rising edge
//  rst             in   1           reset, asynchronous assert, active-low (0 = in reset)
//  s_axi_awid      in   ID_WIDTH    denied write ID
//  s_axi_awlen     in   8           denied write burst length - 1
//  s_axi_awvalid   in   1           AW valid
//  s_axi_awready   out  1           AW ready
//  s_axi_wlast     in   1           last W beat
//  s_axi_wvalid    in   1           W valid (wdata/wstrb not connected; dropped)
//  s_axi_wready    out  1           W ready
//  s_axi_bid       out  ID_WIDTH    B ID
//  s_axi_bresp     out  2           B response, always ERR_RESP
//  s_axi_bvalid    out  1           B valid
//  s_axi_bready    in   1           B ready
//  s_axi_arid      in   ID_WIDTH    denied read ID
//  s_axi_arlen     in   8           denied read burst length - 1
//  s_axi_arvalid   in   1           AR valid
//  s_axi_arready   out  1           AR ready
//  s_axi_rid       out  ID_WIDTH    R ID
//  s_axi_rdata     out  DATA_WIDTH  R data, always RDATA_FILL
//  s_axi_rresp     out  2           R response, always ERR_RESP
//  s_axi_rlast     out  1           last R beat
//  s_axi_rvalid    out  1           R valid
//  s_axi_rready    in   1           R ready
//  proto_err       out  1           1-cycle pulse: W burst length does not match awlen+1
// BEHAVIOUR
//  Reset (rst=0):
//   - Both FSMs go to IDLE.
//   - All valid/ready outputs are 0; bid, rid and rlast are 0; proto_err is 0.
//   - awready and arready remain 0 for one cycle after reset release (registered ready_en flop).
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: awready=1, wready=0. On AW handshake, latch awid into bid, clear wcnt, go to W_DATA.
//   - W_DATA: wready=1. Each W handshake increments the 9-bit wcnt.
//     The burst ends on the W handshake with wlast=1; go to W_RESP.
//     If the W handshake count at wlast differs from awlen+1, pulse proto_err in the next cycle.
//     If wcnt reaches awlen+1 without wlast, pulse proto_err once; keep draining until wlast.
//   - W_RESP: bvalid=1, wready=0, awready=0. bvalid rises the cycle after the wlast handshake.
//     On bready go to W_IDLE. bvalid/bid hold stable until the handshake.
//   - W beats presented before AW are stalled (wready=0). This is legal AXI.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   - R_IDLE: arready=1. On AR handshake, latch arid into rid and arlen into the 8-bit rcnt;
//     go to R_DATA. First beat is valid the next cycle.
//   - R_DATA: rvalid=1. rlast=(rcnt==0). On each R handshake, rcnt decrements.
//     The handshake with rlast=1 goes to R_IDLE.
//     Beats are back-to-back while rready=1. rvalid/rlast/rid hold stable while rready=0.
//   - arlen=0 gives a single beat with rlast=1. arlen=255 gives 256 beats with no wrap;
//     rcnt is not decremented past 0.
//  Channel independence: AW and AR handshakes in the same cycle are both accepted.
//  Reset mid-burst: state is aborted immediately and no partial response is completed.
//  Throughput: ready returns in IDLE the cycle after the final B/R handshake (1 bubble per transaction).
// TESTING
//  1. AR id=8'h5A, len=3, rready=1 -> 4 R beats on consecutive cycles; rid=5A, rresp=11, rdata=0,
//     rlast on beat 4 only.
//  2. AW id=8'h11, len=1; 2 W beats, wlast on beat 2; bready=1 -> bvalid 1 cycle after wlast
//     handshake; bid=11, bresp=11, no proto_err.
//  3. AW len=3, wlast on beat 2 -> proto_err pulses once; B issued after beat 2.
//  4. rready toggled 1/0 during AR len=7; bready held 0 for 5 cycles -> outputs stable while stalled;
//     exactly 8 beats and one B.
//  5. AW and AR in same cycle, AR len=0 -> both accepted; single R beat with rlast=1 concurrent with W drain.
//  6. rst=0 asserted in R_DATA beat 2 of len=3 -> rvalid=0 at once; after release, arready=0 for 1 cycle, then 1.

Source files
------------

// File: rtl/axi_pmp_err_responder.sv
// Terminating AXI4 slave for IO-PMP denied transactions: drains AW/W and AR,
// answers every request with ERR_RESP on B, or on R for the full burst length.
module axi_pmp_err_responder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter logic [1:0]  ERR_RESP   = 2'b11,
  parameter logic [31:0] RDATA_FILL = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [7:0]            s_axi_awlen,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [7:0]            s_axi_arlen,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  proto_err
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  wstate_t     wstate;
  rstate_t     rstate;
  logic        ready_en;
  logic [8:0]  wcnt;
  logic [8:0]  wexp;
  logic [8:0]  wcnt_inc;
  logic        len_err_seen;
  logic [7:0]  rcnt;

  assign wcnt_inc = wcnt + 9'd1;

  // Holds AW/AR ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate       <= W_IDLE;
      s_axi_bid    <= '0;
      wcnt         <= '0;
      wexp         <= '0;
      len_err_seen <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      proto_err <= 1'b0;
      case (wstate)
        W_IDLE: if (s_axi_awvalid && ready_en) begin
          s_axi_bid    <= s_axi_awid;
          wexp         <= {1'b0, s_axi_awlen} + 9'd1;
          wcnt         <= '0;
          len_err_seen <= 1'b0;
          wstate       <= W_DATA;
        end
        W_DATA: if (s_axi_wvalid) begin
          wcnt <= wcnt_inc;
          // Error when wlast disagrees with the announced length: early wlast,
          // or the expected last beat arriving without wlast. One pulse per burst.
          if (!len_err_seen && (s_axi_wlast != (wcnt_inc == wexp))) begin
            proto_err    <= 1'b1;
            len_err_seen <= 1'b1;
          end
          if (s_axi_wlast) wstate <= W_RESP;
        end
        W_RESP: if (s_axi_bready) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate    <= R_IDLE;
      s_axi_rid <= '0;
      rcnt      <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (s_axi_arvalid && ready_en) begin
          s_axi_rid <= s_axi_arid;
          rcnt      <= s_axi_arlen;
          rstate    <= R_DATA;
        end
        R_DATA: if (s_axi_rready) begin
          if (rcnt == '0) rstate <= R_IDLE;
          else            rcnt   <= rcnt - 8'd1;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = ready_en && (wstate == W_IDLE);
  assign s_axi_wready  = (wstate == W_DATA);
  assign s_axi_bvalid  = (wstate == W_RESP);
  assign s_axi_bresp   = ERR_RESP;

  assign s_axi_arready = ready_en && (rstate == R_IDLE);
  assign s_axi_rvalid  = (rstate == R_DATA);
  assign s_axi_rlast   = (rstate == R_DATA) && (rcnt == '0);
  assign s_axi_rresp   = ERR_RESP;
  assign s_axi_rdata   = DATA_WIDTH'(RDATA_FILL);

endmodule

// File: tb/tb_axi_pmp_err_responder.sv
// Bench for axi_pmp_err_responder: directed cycle table, random traffic against a
// transaction-level model, and hand sequences for overrun, 256-beat read and reset.
module tb_axi_pmp_err_responder;
  localparam int DW = 32;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] s_axi_awid = '0, s_axi_arid = '0, s_axi_bid, s_axi_rid;
  logic [7:0]    s_axi_awlen = '0, s_axi_arlen = '0;
  logic          s_axi_awvalid = 0, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_bready = 0;
  logic          s_axi_arvalid = 0, s_axi_rready = 0;
  logic          s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, proto_err;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic [DW-1:0] s_axi_rdata;

  always #5 clk = ~clk;

  axi_pmp_err_responder #(
    .DATA_WIDTH(DW), .ID_WIDTH(IW), .ERR_RESP(2'b11), .RDATA_FILL(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .proto_err(proto_err)
  );

  int applied = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       arvalid; logic [7:0] arid; logic [7:0] arlen; logic rready;
    logic       awvalid; logic [7:0] awid; logic [7:0] awlen;
    logic       wvalid;  logic wlast; logic bready;
    logic       e_arready, e_rvalid, e_rlast; logic [7:0] e_rid;
    logic       e_awready, e_wready, e_bvalid; logic [7:0] e_bid; logic e_pe;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [7:0] aid, input logic [7:0] alen, input logic rr,
    input logic awv, input logic [7:0] wid, input logic [7:0] wlen,
    input logic wv, input logic wl, input logic br,
    input logic e_ar, input logic e_rv, input logic e_rl, input logic [7:0] e_rid,
    input logic e_aw, input logic e_w, input logic e_bv, input logic [7:0] e_bid,
    input logic e_pe);
    vec_t v;
    v.arvalid = av;  v.arid = aid; v.arlen = alen; v.rready = rr;
    v.awvalid = awv; v.awid = wid; v.awlen = wlen;
    v.wvalid = wv;   v.wlast = wl; v.bready = br;
    v.e_arready = e_ar; v.e_rvalid = e_rv; v.e_rlast = e_rl; v.e_rid = e_rid;
    v.e_awready = e_aw; v.e_wready = e_w; v.e_bvalid = e_bv; v.e_bid = e_bid;
    v.e_pe = e_pe;
    return v;
  endfunction

  // Transaction-level reference: queue of expected R beats {last,id}, queue of
  // pending B ids, and the write burst currently being drained.
  logic [8:0] rq[$];
  logic [7:0] bq[$];
  logic       aw_act = 0, flagged = 0, pe_exp = 0;
  logic [7:0] aw_id = '0;
  int         aw_len = 0, wbeats = 0;

  task automatic model_cycle();
    logic e_ar, e_aw;
    #1;
    e_ar = (rq.size() == 0);
    e_aw = !aw_act && (bq.size() == 0);
    chk("rnd arready", s_axi_arready, e_ar);
    chk("rnd rvalid", s_axi_rvalid, rq.size() != 0);
    if (rq.size() != 0) begin
      chk("rnd rid", s_axi_rid, rq[0][7:0]);
      chk("rnd rlast", s_axi_rlast, rq[0][8]);
      chk("rnd rdata", s_axi_rdata, 0);
      chk("rnd rresp", s_axi_rresp, 2'b11);
    end
    chk("rnd awready", s_axi_awready, e_aw);
    chk("rnd wready", s_axi_wready, aw_act);
    chk("rnd bvalid", s_axi_bvalid, bq.size() != 0);
    if (bq.size() != 0) begin
      chk("rnd bid", s_axi_bid, bq[0]);
      chk("rnd bresp", s_axi_bresp, 2'b11);
    end
    chk("rnd proto_err", proto_err, pe_exp);
    pe_exp = 1'b0;
    if (rq.size() != 0) begin
      if (s_axi_rready) void'(rq.pop_front());
    end else if (s_axi_arvalid) begin
      for (int i = 0; i <= int'(s_axi_arlen); i++)
        rq.push_back({(i == int'(s_axi_arlen)), s_axi_arid});
    end
    if (bq.size() != 0 && s_axi_bready) void'(bq.pop_front());
    if (s_axi_awvalid && e_aw) begin
      aw_act = 1'b1; aw_id = s_axi_awid; aw_len = int'(s_axi_awlen);
      wbeats = 0; flagged = 1'b0;
    end else if (aw_act && s_axi_wvalid) begin
      wbeats++;
      if (!flagged && (s_axi_wlast != (wbeats == aw_len + 1))) begin
        pe_exp = 1'b1; flagged = 1'b1;
      end
      if (s_axi_wlast) begin
        aw_act = 1'b0;
        bq.push_back(aw_id);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    int beats, lasts, badid, pulses, cyc;
    logic done;

    // Directed cycle table; each row = inputs for one cycle and the outputs seen in it.
    //             ar: v id   len rr | aw: v id   len wv wl br | e: ar rv rl rid  aw w bv bid  pe
    tbl.push_back(mk(1, 8'h5A, 3, 1,  0, 0,     0, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 1,  0, 0,     0, 0, 0, 0,   0, 1, 0, 8'h5A, 1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 1,  0, 0,     0, 0, 0, 0,   0, 1, 0, 8'h5A, 1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 1,  0, 0,     0, 0, 0, 0,   0, 1, 0, 8'h5A, 1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 1,  0, 0,     0, 0, 0, 0,   0, 1, 1, 8'h5A, 1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  1, 8'h11, 1, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 1, 0, 0,   1, 0, 0, 0,     0, 1, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 1, 1, 0,   1, 0, 0, 0,     0, 1, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 1,   1, 0, 0, 0,     0, 0, 1, 8'h11, 0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  1, 8'h22, 3, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 1, 0, 0,   1, 0, 0, 0,     0, 1, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 1, 1, 0,   1, 0, 0, 0,     0, 1, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 0,   1, 0, 0, 0,     0, 0, 1, 8'h22, 1));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 1,   1, 0, 0, 0,     0, 0, 1, 8'h22, 0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(1, 8'h44, 0, 1,  1, 8'h33, 0, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 1,  0, 0,     0, 1, 1, 0,   0, 1, 1, 8'h44, 0, 1, 0, 0,     0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 1,   1, 0, 0, 0,     0, 0, 1, 8'h33, 0));
    tbl.push_back(mk(0, 0,     0, 0,  0, 0,     0, 0, 0, 0,   1, 0, 0, 0,     1, 0, 0, 0,     0));

    // Reset state
    tick(); tick();
    chk("rst arready", s_axi_arready, 0);
    chk("rst awready", s_axi_awready, 0);
    chk("rst wready", s_axi_wready, 0);
    chk("rst bvalid", s_axi_bvalid, 0);
    chk("rst rvalid", s_axi_rvalid, 0);
    chk("rst rlast", s_axi_rlast, 0);
    chk("rst bid", s_axi_bid, 0);
    chk("rst rid", s_axi_rid, 0);
    chk("rst proto_err", proto_err, 0);
    rst = 1'b1;
    #1;
    chk("post-rst arready", s_axi_arready, 0);
    chk("post-rst awready", s_axi_awready, 0);
    tick();

    foreach (tbl[k]) begin
      s_axi_arvalid = tbl[k].arvalid; s_axi_arid = tbl[k].arid; s_axi_arlen = tbl[k].arlen;
      s_axi_rready  = tbl[k].rready;
      s_axi_awvalid = tbl[k].awvalid; s_axi_awid = tbl[k].awid; s_axi_awlen = tbl[k].awlen;
      s_axi_wvalid  = tbl[k].wvalid;  s_axi_wlast = tbl[k].wlast; s_axi_bready = tbl[k].bready;
      #1;
      chk($sformatf("v%0d arready", k), s_axi_arready, tbl[k].e_arready);
      chk($sformatf("v%0d rvalid", k), s_axi_rvalid, tbl[k].e_rvalid);
      chk($sformatf("v%0d awready", k), s_axi_awready, tbl[k].e_awready);
      chk($sformatf("v%0d wready", k), s_axi_wready, tbl[k].e_wready);
      chk($sformatf("v%0d bvalid", k), s_axi_bvalid, tbl[k].e_bvalid);
      chk($sformatf("v%0d proto_err", k), proto_err, tbl[k].e_pe);
      if (tbl[k].e_rvalid) begin
        chk($sformatf("v%0d rlast", k), s_axi_rlast, tbl[k].e_rlast);
        chk($sformatf("v%0d rid", k), s_axi_rid, tbl[k].e_rid);
        chk($sformatf("v%0d rdata", k), s_axi_rdata, 0);
        chk($sformatf("v%0d rresp", k), s_axi_rresp, 2'b11);
      end
      if (tbl[k].e_bvalid) begin
        chk($sformatf("v%0d bid", k), s_axi_bid, tbl[k].e_bid);
        chk($sformatf("v%0d bresp", k), s_axi_bresp, 2'b11);
      end
      tick();
    end

    // Random traffic with stalls on both response channels
    for (int n = 0; n < 1500; n++) begin
      s_axi_arvalid = ($urandom_range(0, 3) == 0);
      s_axi_arid    = 8'($urandom);
      s_axi_arlen   = 8'($urandom_range(0, 7));
      s_axi_rready  = ($urandom_range(0, 2) != 0);
      s_axi_awvalid = ($urandom_range(0, 3) == 0);
      s_axi_awid    = 8'($urandom);
      s_axi_awlen   = 8'($urandom_range(0, 5));
      s_axi_wvalid  = ($urandom_range(0, 3) != 0);
      s_axi_wlast   = (aw_act && (wbeats + 1 == aw_len + 1)) ? ($urandom_range(0, 7) != 0)
                                                              : ($urandom_range(0, 7) == 0);
      s_axi_bready  = ($urandom_range(0, 2) == 0);
      model_cycle();
    end
    s_axi_arvalid = 0; s_axi_awvalid = 0;
    s_axi_rready = 1; s_axi_bready = 1; s_axi_wvalid = 1; s_axi_wlast = 1;
    for (int n = 0; n < 20; n++) model_cycle();
    s_axi_rready = 0; s_axi_bready = 0; s_axi_wvalid = 0; s_axi_wlast = 0;
    model_cycle();

    // Over-long W burst: awlen=1, four beats, wlast on the fourth
    s_axi_awvalid = 1; s_axi_awid = 8'h66; s_axi_awlen = 8'd1;
    #1; chk("ovr awready", s_axi_awready, 1);
    tick();
    s_axi_awvalid = 0;
    beats = 0; pulses = 0; cyc = 0;
    while (!s_axi_bvalid && cyc < 20) begin
      s_axi_wvalid = (beats < 4);
      s_axi_wlast  = (beats == 3);
      #1;
      if (proto_err) pulses++;
      if (s_axi_wvalid && s_axi_wready) beats++;
      tick();
      cyc++;
    end
    if (proto_err) pulses++;
    s_axi_wvalid = 0; s_axi_wlast = 0;
    chk("ovr beats", beats, 4);
    chk("ovr proto_err pulses", pulses, 1);
    chk("ovr bvalid", s_axi_bvalid, 1);
    chk("ovr bid", s_axi_bid, 8'h66);
    s_axi_bready = 1; tick(); s_axi_bready = 0;
    chk("ovr idle awready", s_axi_awready, 1);

    // 256-beat read
    s_axi_arvalid = 1; s_axi_arid = 8'h77; s_axi_arlen = 8'd255; s_axi_rready = 1;
    #1; chk("r256 arready", s_axi_arready, 1);
    tick();
    s_axi_arvalid = 0;
    beats = 0; lasts = 0; badid = 0; done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (s_axi_rvalid) begin
        beats++;
        if (s_axi_rid !== 8'h77) badid++;
        if (s_axi_rlast) begin lasts++; done = 1; end
      end
      tick();
    end
    chk("r256 beats", beats, 256);
    chk("r256 rlast count", lasts, 1);
    chk("r256 bad rid", badid, 0);
    chk("r256 arready after", s_axi_arready, 1);
    chk("r256 rvalid after", s_axi_rvalid, 0);

    // Reset during beat 2 of a 4-beat read
    s_axi_arvalid = 1; s_axi_arid = 8'h5A; s_axi_arlen = 8'd3; s_axi_rready = 1;
    tick();
    s_axi_arvalid = 0;
    tick();
    chk("mid rvalid before rst", s_axi_rvalid, 1);
    rst = 1'b0;
    #1;
    chk("mid rst rvalid", s_axi_rvalid, 0);
    chk("mid rst rlast", s_axi_rlast, 0);
    chk("mid rst rid", s_axi_rid, 0);
    chk("mid rst arready", s_axi_arready, 0);
    chk("mid rst awready", s_axi_awready, 0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid release arready", s_axi_arready, 0);
    chk("mid release awready", s_axi_awready, 0);
    tick();
    chk("mid ready arready", s_axi_arready, 1);
    chk("mid ready awready", s_axi_awready, 1);
    chk("mid ready rvalid", s_axi_rvalid, 0);
    tick();
    chk("mid no partial rvalid", s_axi_rvalid, 0);
    chk("mid no partial bvalid", s_axi_bvalid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
